// File: rtl/psram_arbiter_if.sv
// Client and controller-side signals of the PSRAM arbiter, bundled for the arbiter ports.
// With PSRAM_ARB_STATS_EN defined the interface also carries the burst statistics outputs.
interface psram_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 64
);
  logic              i_rd_req;
  logic              o_rd_gnt;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_data_valid;
  logic              i_wr_req;
  logic              o_wr_gnt;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_data_ack;
  logic              o_cmd_valid;
  logic              i_cmd_ready;
  logic [ADDR_W-1:0] o_cmd_addr;
  logic              o_cmd_write;
  logic [DATA_W-1:0] i_cmd_rdata;
  logic              i_cmd_rdata_valid;
  logic [DATA_W-1:0] o_cmd_wdata;
  logic              i_cmd_wdata_req;
  logic              i_cmd_done;
`ifdef PSRAM_ARB_STATS_EN
  logic [15:0]       o_stat_rd_bursts;
  logic [15:0]       o_stat_wr_bursts;
  logic [15:0]       o_stat_wr_wait_max;
`endif

  modport slave (
`ifdef PSRAM_ARB_STATS_EN
    output o_stat_rd_bursts, o_stat_wr_bursts, o_stat_wr_wait_max,
`endif
    input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
    input  i_cmd_ready, i_cmd_rdata, i_cmd_rdata_valid, i_cmd_wdata_req, i_cmd_done,
    output o_rd_gnt, o_rd_data, o_rd_data_valid, o_wr_gnt, o_wr_data_ack,
    output o_cmd_valid, o_cmd_addr, o_cmd_write, o_cmd_wdata
  );

  modport master (
`ifdef PSRAM_ARB_STATS_EN
    input  o_stat_rd_bursts, o_stat_wr_bursts, o_stat_wr_wait_max,
`endif
    output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
    output i_cmd_ready, i_cmd_rdata, i_cmd_rdata_valid, i_cmd_wdata_req, i_cmd_done,
    input  o_rd_gnt, o_rd_data, o_rd_data_valid, o_wr_gnt, o_wr_data_ack,
    input  o_cmd_valid, o_cmd_addr, o_cmd_write, o_cmd_wdata
  );
endinterface

// File: rtl/psram_arbiter.sv
// Shares the PSRAM controller command port between the display reader (R) and the pixel writer (W).
// Optional burst statistics are compiled in with `define PSRAM_ARB_STATS_EN.
module psram_arbiter #(
  parameter int ADDR_W        = 21,
  parameter int DATA_W        = 64,
  parameter int BEATS         = 8,
  parameter int MAX_RD_STREAK = 4
) (
  input logic i_psram_clk,
  input logic i_psram_rst,
  psram_arbiter_if.slave bus
);
  localparam int BW = $clog2(BEATS + 1);
  localparam logic [2:0]    STREAK_MAX = 3'(MAX_RD_STREAK);
  localparam logic [BW-1:0] BEAT_LIM   = BW'(BEATS);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;   // 1 = W owns the port
  logic [2:0]        streak;
  logic [BW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] live_addr;
  logic              beat_ok, beat;
  logic              rd_gnt, wr_gnt, rd_dv, wr_ack, cmd_valid, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  assign live_addr = owner ? bus.i_wr_addr : bus.i_rd_addr;
  assign beat_ok   = beat_cnt < BEAT_LIM;
  assign beat      = owner ? bus.i_cmd_wdata_req : bus.i_cmd_rdata_valid;

  always_ff @(posedge i_psram_clk) begin
    if (i_psram_rst) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: if (bus.i_rd_req || bus.i_wr_req) begin
        state_nxt = ISSUE;
        // R keeps priority until W has watched MAX_RD_STREAK R bursts go by
        owner_nxt = bus.i_wr_req && (!bus.i_rd_req || streak == STREAK_MAX);
      end
      ISSUE:   if (bus.i_cmd_ready) state_nxt = BUSY;
      BUSY:    if (bus.i_cmd_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = addr_q;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    rd_dv     = 1'b0;
    wr_ack    = 1'b0;
    cmd_wdata = '0;
    case (state)
      ISSUE: begin
        cmd_valid = 1'b1;
        cmd_write = owner;
        cmd_addr  = live_addr;
        rd_gnt    = bus.i_cmd_ready && !owner;
        wr_gnt    = bus.i_cmd_ready && owner;
      end
      BUSY: begin
        if (owner) begin
          wr_ack    = bus.i_cmd_wdata_req && beat_ok;
          cmd_wdata = bus.i_wr_data;
        end else begin
          rd_dv = bus.i_cmd_rdata_valid && beat_ok;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_cmd_valid     = cmd_valid;
  assign bus.o_cmd_write     = cmd_write;
  assign bus.o_cmd_addr      = cmd_addr;
  assign bus.o_rd_gnt        = rd_gnt;
  assign bus.o_wr_gnt        = wr_gnt;
  assign bus.o_rd_data_valid = rd_dv;
  assign bus.o_rd_data       = bus.i_cmd_rdata;
  assign bus.o_wr_data_ack   = wr_ack;
  assign bus.o_cmd_wdata     = cmd_wdata;

  always_ff @(posedge i_psram_clk) begin
    if (i_psram_rst) begin
      owner  <= 1'b0;
      addr_q <= '0;
      streak <= '0;
    end else begin
      owner <= owner_nxt;
      if (rd_gnt || wr_gnt) addr_q <= live_addr;
      if (wr_gnt)
        streak <= '0;
      else if (rd_gnt && bus.i_wr_req && streak != STREAK_MAX)
        streak <= streak + 3'd1;
      else if (state == IDLE && !bus.i_wr_req)
        streak <= '0;
    end
  end

  // Beats past BEATS in one burst are swallowed rather than forwarded
  always_ff @(posedge i_psram_clk) begin
    if (i_psram_rst || state != BUSY) beat_cnt <= '0;
    else if (beat && beat_ok)         beat_cnt <= beat_cnt + 1'b1;
  end

`ifdef PSRAM_ARB_STATS_EN
  logic [15:0] stat_rd, stat_wr, wait_max, wait_cnt;

  always_ff @(posedge i_psram_clk) begin
    if (i_psram_rst) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      wait_max <= '0;
      wait_cnt <= '0;
    end else begin
      if (rd_gnt) stat_rd <= stat_rd + 16'd1;
      if (wr_gnt) begin
        stat_wr  <= stat_wr + 16'd1;
        wait_cnt <= '0;
        if (wait_cnt > wait_max) wait_max <= wait_cnt;
      end else if (bus.i_wr_req && wait_cnt != 16'hFFFF) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

  assign bus.o_stat_rd_bursts   = stat_rd;
  assign bus.o_stat_wr_bursts   = stat_wr;
  assign bus.o_stat_wr_wait_max = wait_max;
`endif
endmodule

// File: tb/tb_psram_arbiter.sv
// Directed plus randomized bench for psram_arbiter; the bench plays both clients and the controller.
module tb_psram_arbiter;
  localparam int ADDR_W        = 21;
  localparam int DATA_W        = 64;
  localparam int BEATS         = 8;
  localparam int MAX_RD_STREAK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  psram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .MAX_RD_STREAK(MAX_RD_STREAK)
  ) dut (
    .i_psram_clk(clk),
    .i_psram_rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int m_streak = 0;      // R grants W has watched while waiting
  bit gnt_log[$];        // 0 = R, 1 = W, in grant order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled mid-low-phase, far from the rising edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic burst(input int rdy_dly, input int nbeats, input bit stray,
                       input bit keep_r, input bit keep_w, input int exp_lat, input bit no_done);
    bit w;
    int n;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] ea;
    w  = bus.i_wr_req && (!bus.i_rd_req || m_streak >= MAX_RD_STREAK);
    ea = w ? bus.i_wr_addr : bus.i_rd_addr;
    if (!bus.i_wr_req) m_streak = 0;
    n = 0;
    tick(); n++;
    while (!bus.o_cmd_valid && n < 6) begin
      chk("early_gnt", {62'd0, bus.o_rd_gnt, bus.o_wr_gnt}, 64'd0);
      tick(); n++;
    end
    chk("cmd_valid", bus.o_cmd_valid, 1);
    if (!bus.o_cmd_valid) return;
    if (exp_lat > 0) chk("req_latency", n, exp_lat);
    chk("cmd_write", bus.o_cmd_write, w);
    chk("cmd_addr", bus.o_cmd_addr, ea);
    for (int k = 0; k < rdy_dly; k++) begin
      chk("gnt_before_ready", {62'd0, bus.o_rd_gnt, bus.o_wr_gnt}, 64'd0);
      tick();
      chk("valid_held", bus.o_cmd_valid, 1);
    end
    bus.i_cmd_ready = 1'b1;
    #1;
    chk("rd_gnt", bus.o_rd_gnt, !w);
    chk("wr_gnt", bus.o_wr_gnt, w);
    gnt_log.push_back(w);
    if (w) m_streak = 0;
    else if (bus.i_wr_req && m_streak < MAX_RD_STREAK) m_streak++;
    tick();
    bus.i_cmd_ready = 1'b0;
    if (!w && !keep_r) bus.i_rd_req = 1'b0;
    if (w && !keep_w)  bus.i_wr_req = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom, $urandom};
      if (w) begin
        bus.i_cmd_wdata_req   = 1'b1;
        bus.i_wr_data         = d;
        bus.i_cmd_rdata_valid = stray;
        bus.i_cmd_rdata       = ~d;
      end else begin
        bus.i_cmd_rdata_valid = 1'b1;
        bus.i_cmd_rdata       = d;
        bus.i_cmd_wdata_req   = stray;
      end
      #1;
      if (i == 0) chk("busy_no_valid", bus.o_cmd_valid, 0);
      if (w) begin
        chk("wr_ack", bus.o_wr_data_ack, (i < BEATS));
        if (i < BEATS) chk("cmd_wdata", bus.o_cmd_wdata, d);
        chk("rd_dv_in_w", bus.o_rd_data_valid, 0);
      end else begin
        chk("rd_dv", bus.o_rd_data_valid, (i < BEATS));
        if (i < BEATS) chk("rd_data", bus.o_rd_data, d);
        chk("wr_ack_in_r", bus.o_wr_data_ack, 0);
      end
      tick();
      bus.i_cmd_wdata_req   = 1'b0;
      bus.i_cmd_rdata_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    if (no_done) return;
    bus.i_cmd_done = 1'b1;
    #1;
    chk("done_no_valid", bus.o_cmd_valid, 0);
    tick();
    bus.i_cmd_done = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, bus.o_cmd_valid, 0);
    chk({tag, "_gnts"}, {62'd0, bus.o_rd_gnt, bus.o_wr_gnt}, 64'd0);
    chk({tag, "_rd_dv"}, bus.o_rd_data_valid, 0);
    chk({tag, "_wr_ack"}, bus.o_wr_data_ack, 0);
    chk({tag, "_write"}, bus.o_cmd_write, 0);
    chk({tag, "_addr"}, bus.o_cmd_addr, 0);
  endtask

  initial begin
    bit exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int base;
`ifdef PSRAM_ARB_STATS_EN
    logic [15:0] rd0, wr0;
`endif
    bus.i_rd_req = 0; bus.i_rd_addr = '0; bus.i_wr_req = 0; bus.i_wr_addr = '0;
    bus.i_wr_data = '0; bus.i_cmd_ready = 0; bus.i_cmd_rdata = '0;
    bus.i_cmd_rdata_valid = 0; bus.i_cmd_wdata_req = 0; bus.i_cmd_done = 0;

    repeat (3) tick();
    chk_quiet("reset");
    rst = 1'b0;

    // R only, then W only
    bus.i_rd_addr = 21'h000020; bus.i_rd_req = 1'b1;
    burst(0, 8, 0, 0, 0, 1, 0);
    bus.i_wr_addr = 21'h010000; bus.i_wr_req = 1'b1;
    burst(0, 8, 0, 0, 0, 1, 0);

    // Both held continuously: W forced in after MAX_RD_STREAK R bursts
`ifdef PSRAM_ARB_STATS_EN
    rd0 = bus.o_stat_rd_bursts; wr0 = bus.o_stat_wr_bursts;
`endif
    base = gnt_log.size();
    bus.i_rd_addr = 21'h000100; bus.i_wr_addr = 21'h000200;
    bus.i_rd_req = 1'b1; bus.i_wr_req = 1'b1;
    for (int i = 0; i < 10; i++) burst(i % 3, 8, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) chk("streak_order", gnt_log[base+i], exp3[i]);
    bus.i_rd_req = 1'b0; bus.i_wr_req = 1'b0;
    tick();
    m_streak = 0;
`ifdef PSRAM_ARB_STATS_EN
    chk("stat_rd", bus.o_stat_rd_bursts - rd0, 8);
    chk("stat_wr", bus.o_stat_wr_bursts - wr0, 2);
`endif

    // Simultaneous requests from IDLE with an empty streak
    base = gnt_log.size();
    bus.i_rd_req = 1'b1; bus.i_wr_req = 1'b1;
    burst(1, 8, 0, 0, 0, 1, 0);
    burst(0, 8, 0, 0, 0, 1, 0);
    chk("tie_first_r", gnt_log[base], 0);
    chk("tie_then_w", gnt_log[base+1], 1);

    // Over-long and short bursts
    bus.i_wr_addr = 21'h1FFFFF; bus.i_wr_req = 1'b1;
    burst(2, 11, 0, 0, 0, 0, 0);
    bus.i_rd_addr = 21'h0ABCDE; bus.i_rd_req = 1'b1;
    burst(0, 5, 1, 0, 0, 0, 0);

    // Reset in the middle of a read burst
    bus.i_rd_addr = 21'h000040; bus.i_rd_req = 1'b1;
    burst(0, 3, 0, 0, 0, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_cmd_rdata_valid = 1'b1; bus.i_cmd_wdata_req = 1'b1;
    #1;
    chk_quiet("mid_reset");
    bus.i_cmd_rdata_valid = 1'b0; bus.i_cmd_wdata_req = 1'b0;
    m_streak = 0;
    bus.i_rd_addr = 21'h000080; bus.i_rd_req = 1'b1;
    burst(0, 8, 0, 0, 0, 1, 0);

    // Stray read beats during a write burst
    bus.i_wr_addr = 21'h000300; bus.i_wr_req = 1'b1;
    burst(1, 8, 1, 0, 0, 0, 0);

    // Random traffic against the priority model
    for (int it = 0; it < 60; it++) begin
      if (!bus.i_rd_req && $urandom_range(0, 2) != 0) begin
        bus.i_rd_req = 1'b1; bus.i_rd_addr = ADDR_W'($urandom);
      end
      if (!bus.i_wr_req && $urandom_range(0, 1) != 0) begin
        bus.i_wr_req = 1'b1; bus.i_wr_addr = ADDR_W'($urandom);
      end
      if (!bus.i_rd_req && !bus.i_wr_req) begin
        bus.i_cmd_rdata_valid = 1'b1; bus.i_cmd_wdata_req = 1'b1;
        #1;
        chk("idle_stray_rd", bus.o_rd_data_valid, 0);
        chk("idle_stray_wr", bus.o_wr_data_ack, 0);
        tick();
        bus.i_cmd_rdata_valid = 1'b0; bus.i_cmd_wdata_req = 1'b0;
        m_streak = 0;
      end else begin
        burst($urandom_range(0, 3), $urandom_range(3, 10), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
